// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, ALU-side and response signals of the shared-ALU arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface alu_share_arbiter_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned CTR_W = 4
);
  // Requester 0 (main datapath)
  logic             req0_valid;
  logic             req0_ready;
  logic [CTR_W-1:0] req0_ctr;
  logic             req0_srca;
  logic             req0_srcb;
  logic [W-1:0]     req0_busa;
  logic [W-1:0]     req0_busb;
  logic [4:0]       req0_shamt;
  logic [15:0]      req0_imm;
  logic [W-1:0]     req0_extend;
  // Requester 1 (aux / multicycle unit)
  logic             req1_valid;
  logic             req1_ready;
  logic [CTR_W-1:0] req1_ctr;
  logic             req1_srca;
  logic             req1_srcb;
  logic [W-1:0]     req1_busa;
  logic [W-1:0]     req1_busb;
  logic [4:0]       req1_shamt;
  logic [15:0]      req1_imm;
  logic [W-1:0]     req1_extend;
  // Registered operand set towards the ALU, and its result
  logic             alu_srca;
  logic             alu_srcb;
  logic [W-1:0]     alu_busa;
  logic [W-1:0]     alu_busb;
  logic [4:0]       alu_shamt;
  logic [15:0]      alu_imm;
  logic [W-1:0]     alu_extend;
  logic [CTR_W-1:0] alu_ctr;
  logic [W-1:0]     alu_result;
  logic             alu_zero;
  // Tagged response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [W-1:0]     rsp_result;
  logic             rsp_zero;

  modport slave (
    input  req0_valid, req0_ctr, req0_srca, req0_srcb, req0_busa, req0_busb,
           req0_shamt, req0_imm, req0_extend,
    input  req1_valid, req1_ctr, req1_srca, req1_srcb, req1_busa, req1_busb,
           req1_shamt, req1_imm, req1_extend,
    output req0_ready, req1_ready,
    output alu_srca, alu_srcb, alu_busa, alu_busb, alu_shamt, alu_imm, alu_extend, alu_ctr,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ctr, req0_srca, req0_srcb, req0_busa, req0_busb,
           req0_shamt, req0_imm, req0_extend,
    output req1_valid, req1_ctr, req1_srca, req1_srcb, req1_busa, req1_busb,
           req1_shamt, req1_imm, req1_extend,
    input  req0_ready, req1_ready,
    input  alu_srca, alu_srcb, alu_busa, alu_busb, alu_shamt, alu_imm, alu_extend, alu_ctr,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Flow per transaction: grant in IDLE (operands registered), EXEC (ALU settles one full cycle,
// result captured), RESP (tagged response held until accepted).
// Optional macro ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead of round-robin.
module alu_share_arbiter #(
  parameter int unsigned W     = 32,
  parameter int unsigned CTR_W = 4
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q;
  logic             any_valid;
  logic             grant;
  logic             issue;

  logic             alu_srca_q, alu_srcb_q;
  logic [W-1:0]     alu_busa_q, alu_busb_q, alu_extend_q;
  logic [4:0]       alu_shamt_q;
  logic [15:0]      alu_imm_q;
  logic [CTR_W-1:0] alu_ctr_q;

  logic             rsp_id_q, rsp_zero_q;
  logic [W-1:0]     rsp_result_q;

  // Pick the winning requester index (meaningful only when any_valid)
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
`ifdef ARB_FIXED_PRIO_EN
    grant = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
`endif
    issue = (state_q == StIdle) && any_valid;
  end

  // Next-state logic for the IDLE -> EXEC -> RESP loop
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; a reset mid-transaction simply drops it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers only move on a grant edge so the ALU inputs are quiet during EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      alu_srca_q   <= 1'b0;
      alu_srcb_q   <= 1'b0;
      alu_busa_q   <= '0;
      alu_busb_q   <= '0;
      alu_shamt_q  <= '0;
      alu_imm_q    <= '0;
      alu_extend_q <= '0;
      alu_ctr_q    <= '0;
    end else if (issue) begin
      last_grant_q <= grant;
      alu_srca_q   <= grant ? bus.req1_srca   : bus.req0_srca;
      alu_srcb_q   <= grant ? bus.req1_srcb   : bus.req0_srcb;
      alu_busa_q   <= grant ? bus.req1_busa   : bus.req0_busa;
      alu_busb_q   <= grant ? bus.req1_busb   : bus.req0_busb;
      alu_shamt_q  <= grant ? bus.req1_shamt  : bus.req0_shamt;
      alu_imm_q    <= grant ? bus.req1_imm    : bus.req0_imm;
      alu_extend_q <= grant ? bus.req1_extend : bus.req0_extend;
      alu_ctr_q    <= grant ? bus.req1_ctr    : bus.req0_ctr;
    end
  end

  // Capture the ALU result at the end of EXEC; last_grant_q still names the owner here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else if (state_q == StExec) begin
      rsp_id_q     <= last_grant_q;
      rsp_result_q <= bus.alu_result;
      rsp_zero_q   <= bus.alu_zero;
    end
  end

  assign bus.req0_ready = issue && !grant;
  assign bus.req1_ready = issue && grant;

  assign bus.alu_srca   = alu_srca_q;
  assign bus.alu_srcb   = alu_srcb_q;
  assign bus.alu_busa   = alu_busa_q;
  assign bus.alu_busb   = alu_busb_q;
  assign bus.alu_shamt  = alu_shamt_q;
  assign bus.alu_imm    = alu_imm_q;
  assign bus.alu_extend = alu_extend_q;
  assign bus.alu_ctr    = alu_ctr_q;

  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule
